// File: rtl/ctrl_fsm_gen2_pkg.sv
// Shared types and constants for the gen2 accumulator-CPU control sequencer.
// Holds the state enum, opcode map and idle ALU code.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_FETCH_INST,
        ST_DECODE,
        ST_FETCH_OP,
        ST_EXEC,
        ST_STORE,
        ST_JUMP,
        ST_HALT
    } ctrl_state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_STA,
        CLS_JUMP,
        CLS_HLT,
        CLS_NOP
    } op_class_t;

    localparam logic [3:0] OP_NOR = 4'h0;
    localparam logic [3:0] OP_AND = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDA = 4'h5;
    localparam logic [3:0] OP_JCC = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_HLT = 4'h9;

    localparam logic [2:0] UAL_IDLE = 3'b111;

    // Memory access states hold for MEM_WAIT+1 enabled cycles.
    function automatic logic is_mem_state(input ctrl_state_t s);
        return (s == ST_FETCH_INST) || (s == ST_FETCH_OP) || (s == ST_STORE);
    endfunction

endpackage

// File: rtl/ctrl_fsm_gen2_mem_wait_cnt.sv
// Memory wait-state counter: counts 0..MEM_WAIT while enabled and flags the
// final cycle of an access through 'last'.
module mem_wait_cnt #(
    parameter int MEM_WAIT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic clr,
    output logic last
);

    logic [2:0] cnt;

    assign last = (cnt == 3'(MEM_WAIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (ce) begin
            if (clr) begin
                cnt <= '0;
            end else if (!last) begin
                cnt <= cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/ctrl_fsm_gen2.sv
// Control sequencer for the accumulator CPU with wait states, jumps and halt.
// Define CTRL_ZERO_FLAG_EN to enable zero-flag control and the JZ opcode.
module ctrl_fsm_gen2
    import ctrl_pkg::*;
#(
    parameter int OP_W     = 4,
    parameter int MEM_WAIT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce,
    input  logic            boot,
    input  logic [OP_W-1:0] code_op,
    input  logic            carry,
    input  logic            zero,
    output logic            clear_PC,
    output logic            enable_PC,
    output logic            load_PC,
    output logic            load_RI,
    output logic            load_R1,
    output logic            load_ACCU,
    output logic            sel_ADR,
    output logic [2:0]      sel_UAL,
    output logic            clear_carry,
    output logic            load_carry,
    output logic            clear_zero,
    output logic            load_zero,
    output logic            enable_mem,
    output logic            W_mem,
    output logic            halted,
    output logic            instr_done
);

`ifdef CTRL_ZERO_FLAG_EN
    localparam bit ZF_EN = 1'b1;
`else
    localparam bit ZF_EN = 1'b0;
`endif

    ctrl_state_t state;
    ctrl_state_t state_next;
    op_class_t   op_class;
    logic [3:0]  op4;
    logic        last;
    logic        cnt_clr;

    assign op4 = code_op[3:0];

    // Counter restarts on any state change, on boot, and outside access states.
    assign cnt_clr = boot || (state_next != state) || !is_mem_state(state);

    mem_wait_cnt #(
        .MEM_WAIT (MEM_WAIT)
    ) u_wait (
        .clk  (clk),
        .rst  (rst),
        .ce   (ce),
        .clr  (cnt_clr),
        .last (last)
    );

    always_comb begin
        op_class = CLS_NOP;
        case (op4)
            OP_NOR, OP_AND, OP_ADD, OP_SUB, OP_LDA: op_class = CLS_ALU;
            OP_STA:                                 op_class = CLS_STA;
            OP_JCC, OP_JMP:                         op_class = CLS_JUMP;
            OP_JZ:                                  op_class = ZF_EN ? CLS_JUMP : CLS_NOP;
            OP_HLT:                                 op_class = CLS_HLT;
            default:                                op_class = CLS_NOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
        end else if (ce) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (boot) begin
            state_next = ST_INIT;
        end else begin
            case (state)
                ST_INIT:       state_next = ST_FETCH_INST;
                ST_FETCH_INST: if (last) state_next = ST_DECODE;
                ST_DECODE: begin
                    case (op_class)
                        CLS_ALU:  state_next = ST_FETCH_OP;
                        CLS_STA:  state_next = ST_STORE;
                        CLS_JUMP: state_next = ST_JUMP;
                        CLS_HLT:  state_next = ST_HALT;
                        default:  state_next = ST_FETCH_INST;
                    endcase
                end
                ST_FETCH_OP:   if (last) state_next = ST_EXEC;
                ST_EXEC:       state_next = ST_FETCH_INST;
                ST_STORE:      if (last) state_next = ST_FETCH_INST;
                ST_JUMP:       state_next = ST_FETCH_INST;
                ST_HALT:       state_next = ST_HALT;
                default:       state_next = ST_INIT;
            endcase
        end
    end

    always_comb begin
        clear_PC    = 1'b0;
        enable_PC   = 1'b0;
        load_PC     = 1'b0;
        load_RI     = 1'b0;
        load_R1     = 1'b0;
        load_ACCU   = 1'b0;
        sel_ADR     = 1'b0;
        sel_UAL     = UAL_IDLE;
        clear_carry = 1'b0;
        load_carry  = 1'b0;
        clear_zero  = 1'b0;
        load_zero   = 1'b0;
        enable_mem  = 1'b0;
        W_mem       = 1'b0;
        halted      = 1'b0;
        instr_done  = 1'b0;
        case (state)
            ST_INIT: begin
                clear_PC    = 1'b1;
                clear_carry = 1'b1;
                clear_zero  = ZF_EN;
            end
            ST_FETCH_INST: begin
                enable_mem = 1'b1;
                load_RI    = last;
            end
            ST_DECODE: begin
                sel_ADR = 1'b1;
                if (op_class == CLS_NOP) begin
                    enable_PC  = 1'b1;
                    instr_done = 1'b1;
                end
            end
            ST_FETCH_OP: begin
                enable_mem = 1'b1;
                sel_ADR    = 1'b1;
                load_R1    = last;
            end
            ST_EXEC: begin
                load_ACCU  = 1'b1;
                enable_PC  = 1'b1;
                instr_done = 1'b1;
                load_zero  = ZF_EN;
                sel_UAL    = op4[2:0];
                load_carry = (op4 == OP_ADD) || (op4 == OP_SUB);
            end
            ST_STORE: begin
                enable_mem = 1'b1;
                sel_ADR    = 1'b1;
                W_mem      = last;
                enable_PC  = last;
                instr_done = last;
            end
            ST_JUMP: begin
                sel_ADR    = 1'b1;
                instr_done = 1'b1;
                case (op4)
                    OP_JCC: begin
                        if (carry) begin
                            enable_PC   = 1'b1;
                            clear_carry = 1'b1;
                        end else begin
                            load_PC = 1'b1;
                        end
                    end
                    OP_JMP:  load_PC = 1'b1;
                    OP_JZ: begin
                        if (ZF_EN && zero) load_PC = 1'b1;
                        else               enable_PC = 1'b1;
                    end
                    default: enable_PC = 1'b1;
                endcase
            end
            ST_HALT: halted = 1'b1;
            default: ;
        endcase
        // Clock enable low keeps address/ALU/halt indication but kills every strobe.
        if (!ce) begin
            clear_PC    = 1'b0;
            enable_PC   = 1'b0;
            load_PC     = 1'b0;
            load_RI     = 1'b0;
            load_R1     = 1'b0;
            load_ACCU   = 1'b0;
            clear_carry = 1'b0;
            load_carry  = 1'b0;
            clear_zero  = 1'b0;
            load_zero   = 1'b0;
            W_mem       = 1'b0;
            instr_done  = 1'b0;
        end
    end

endmodule
